// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the fetch/data memory arbiter.
// Optional perf counters in mem_arbiter are enabled by MEM_ARB_PERF_EN.
package mem_arb_pkg;
  localparam int DEF_MEM_LAT       = 4;
  localparam int DEF_MAX_DM_STREAK = 3;
  localparam int DEF_CNT_W         = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;
endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side bus of the arbiter; slave = arbiter, master = requesters/memory.
interface mem_arb_if;
  logic        if_req, if_done, instrMem_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_rd, dm_wr, dm_done, dataMem_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_done, instrMem_stall, dm_rdata, dm_done, dataMem_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_done, instrMem_stall, dm_rdata, dm_done, dataMem_stall,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lat_counter.sv
// Loadable down-counter; tc flags the last counted cycle (count == 1).
module lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign tc = (cnt == W'(1));
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data requesters, data-priority with bounded streak.
// Define MEM_ARB_PERF_EN to add perf_clr / perf_if_wait / perf_dm_wait stall-cycle counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT       = DEF_MEM_LAT,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
`ifdef MEM_ARB_PERF_EN
  , parameter int CNT_W       = DEF_CNT_W
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arb_if.slave        bus
`ifdef MEM_ARB_PERF_EN
  , input  logic             perf_clr
  , output logic [CNT_W-1:0] perf_if_wait
  , output logic [CNT_W-1:0] perf_dm_wait
`endif
);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);

  state_e        state;
  owner_e        owner;
  logic          acc_wr;
  logic [SW-1:0] streak;
  logic          dm_win, if_win, tc;

  // Fetch is forced through once data has won MAX_DM_STREAK times in a row against it.
  assign dm_win = (bus.dm_rd | bus.dm_wr) & ~(bus.if_req & (streak == SW'(MAX_DM_STREAK)));
  assign if_win = ~dm_win & bus.if_req;

  lat_counter #(.W(LW)) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == ISSUE),
    .value (LW'(MEM_LAT)),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      acc_wr        <= 1'b0;
      streak        <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_done   <= 1'b0;
      bus.dm_done   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (dm_win | if_win) begin
          owner         <= dm_win ? OWN_DM : OWN_IF;
          acc_wr        <= dm_win & bus.dm_wr;
          bus.mem_en    <= 1'b1;
          bus.mem_wr    <= dm_win & bus.dm_wr;
          bus.mem_addr  <= dm_win ? bus.dm_addr : bus.if_addr;
          bus.mem_wdata <= dm_win ? bus.dm_wdata : '0;
          if (dm_win && bus.if_req)
            streak <= (streak == SW'(MAX_DM_STREAK)) ? streak : streak + SW'(1);
          else
            streak <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_wr <= 1'b0;
          state      <= WAIT;
        end
        WAIT: if (tc) begin
          if (!acc_wr) begin
            if (owner == OWN_DM) bus.dm_rdata <= bus.mem_rdata;
            else                 bus.if_rdata <= bus.mem_rdata;
          end
          bus.if_done <= (owner == OWN_IF);
          bus.dm_done <= (owner == OWN_DM);
          state       <= DONE;
        end
        DONE: begin
          bus.if_done <= 1'b0;
          bus.dm_done <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.instrMem_stall = bus.if_req & ~bus.if_done;
  assign bus.dataMem_stall  = (bus.dm_rd | bus.dm_wr) & ~bus.dm_done;

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_wait <= '0;
      perf_dm_wait <= '0;
    end else if (perf_clr) begin
      perf_if_wait <= '0;
      perf_dm_wait <= '0;
    end else begin
      if (bus.instrMem_stall && !(&perf_if_wait)) perf_if_wait <= perf_if_wait + CNT_W'(1);
      if (bus.dataMem_stall  && !(&perf_dm_wait)) perf_dm_wait <= perf_dm_wait + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences, random traffic vs a transaction model.
module tb_mem_arbiter;
  localparam int L = 4, MAXS = 3;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if bus();
`ifdef MEM_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [15:0] perf_if_wait, perf_dm_wait;
`endif

  mem_arbiter #(.MEM_LAT(L), .MAX_DM_STREAK(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    , .perf_clr     (perf_clr)
    , .perf_if_wait (perf_if_wait)
    , .perf_dm_wait (perf_dm_wait)
`endif
  );

  typedef struct {
    logic        if_req;
    logic [15:0] if_addr;
    logic        dm_rd, dm_wr;
    logic [15:0] dm_addr, dm_wdata;
    int          e_if, e_dm;       // done offset from request cycle, -1 = none
    logic [15:0] e_if_r, e_dm_r;
  } vec_t;

  int total = 0, bad = 0, cyc = 0;
  logic        n_rst = 1'b0, n_if_req = 1'b0, n_dm_rd = 1'b0, n_dm_wr = 1'b0;
  logic [15:0] n_if_addr = '0, n_dm_addr = '0, n_dm_wdata = '0;

  logic [15:0] env_mem [1024];
  logic [15:0] ref_mem [1024];
  bit          env_v [32];
  logic [15:0] env_d [32];

  // Transaction model: expected events keyed by absolute cycle (ring of 32).
  bit          e_en [32], e_wr [32], e_ifd [32], e_dmd [32], e_rd [32];
  logic [15:0] e_addr [32], e_wdata [32], e_val [32];
  logic [15:0] x_if_r, x_dm_r;
  int          next_free, streak;
  bit          m_if_done, m_dm_done;

  bit          o_if_done, o_dm_done, o_mem_en;
  logic [15:0] o_mem_addr, o_if_r, o_dm_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      e_en[i] = 0; e_wr[i] = 0; e_ifd[i] = 0; e_dmd[i] = 0; e_rd[i] = 0;
    end
    x_if_r = '0; x_dm_r = '0; next_free = 0; streak = 0;
    m_if_done = 0; m_dm_done = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":if_done"},  bus.if_done,  0);
    chk({tag, ":dm_done"},  bus.dm_done,  0);
    chk({tag, ":if_rdata"}, bus.if_rdata, 0);
    chk({tag, ":dm_rdata"}, bus.dm_rdata, 0);
    chk({tag, ":mem_en"},   bus.mem_en,   0);
    chk({tag, ":mem_wr"},   bus.mem_wr,   0);
    chk({tag, ":mem_addr"}, bus.mem_addr, 0);
    chk({tag, ":mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, ":if_stall"}, bus.instrMem_stall, bus.if_req);
    chk({tag, ":dm_stall"}, bus.dataMem_stall, bus.dm_rd | bus.dm_wr);
  endtask

  task automatic tick();
    int s, s1, s2, g;
    logic [9:0] a;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = n_rst;
    bus.if_req = n_if_req; bus.if_addr = n_if_addr;
    bus.dm_rd = n_dm_rd; bus.dm_wr = n_dm_wr; bus.dm_addr = n_dm_addr; bus.dm_wdata = n_dm_wdata;
    s = cyc % 32;
    if (env_v[s]) begin bus.mem_rdata = env_d[s]; env_v[s] = 0; end
    else bus.mem_rdata = 16'($urandom);
    @(negedge clk);
    o_if_done = bus.if_done; o_dm_done = bus.dm_done; o_mem_en = bus.mem_en;
    o_mem_addr = bus.mem_addr; o_if_r = bus.if_rdata; o_dm_r = bus.dm_rdata;
    if (!rst_n) begin
      check_zero("in_reset");
      model_reset();
      return;
    end
    chk("mem_en", bus.mem_en, e_en[s]);
    if (e_en[s]) begin
      chk("mem_wr", bus.mem_wr, e_wr[s]);
      chk("mem_addr", bus.mem_addr, e_addr[s]);
      if (e_wr[s]) chk("mem_wdata", bus.mem_wdata, e_wdata[s]);
    end
    chk("if_done", bus.if_done, e_ifd[s]);
    chk("dm_done", bus.dm_done, e_dmd[s]);
    if (e_ifd[s] && e_rd[s]) x_if_r = e_val[s];
    if (e_dmd[s] && e_rd[s]) x_dm_r = e_val[s];
    chk("if_rdata", bus.if_rdata, x_if_r);
    chk("dm_rdata", bus.dm_rdata, x_dm_r);
    chk("if_stall", bus.instrMem_stall, n_if_req & ~e_ifd[s]);
    chk("dm_stall", bus.dataMem_stall, (n_dm_rd | n_dm_wr) & ~e_dmd[s]);
    m_if_done = e_ifd[s]; m_dm_done = e_dmd[s];
    e_en[s] = 0; e_wr[s] = 0; e_ifd[s] = 0; e_dmd[s] = 0; e_rd[s] = 0;
    // memory environment: reacts to the strobe it sees
    if (bus.mem_en) begin
      a = bus.mem_addr[9:0];
      if (bus.mem_wr) env_mem[a] = bus.mem_wdata;
      else begin env_v[(cyc + L) % 32] = 1; env_d[(cyc + L) % 32] = env_mem[a]; end
    end
    // arbitration rule applied to this cycle's request levels
    if (cyc >= next_free) begin
      if ((n_dm_rd | n_dm_wr) && !(n_if_req && streak == MAXS)) g = 1;
      else if (n_if_req) g = 0;
      else g = -1;
      if (g >= 0) begin
        s1 = (cyc + 1) % 32; s2 = (cyc + L + 2) % 32;
        e_en[s1] = 1;
        e_wr[s1] = (g == 1) && n_dm_wr;
        e_addr[s1] = (g == 1) ? n_dm_addr : n_if_addr;
        e_wdata[s1] = n_dm_wdata;
        if (g == 1) e_dmd[s2] = 1; else e_ifd[s2] = 1;
        a = e_addr[s1][9:0];
        e_rd[s2] = !e_wr[s1];
        if (e_wr[s1]) ref_mem[a] = n_dm_wdata; else e_val[s2] = ref_mem[a];
        streak = (g == 1 && n_if_req) ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        next_free = cyc + L + 3;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int start, got_if, got_dm, n_en;
    logic [15:0] r_if, r_dm;
    start = cyc + 1; got_if = -1; got_dm = -1; n_en = 0; r_if = '0; r_dm = '0;
    n_if_req = v.if_req; n_if_addr = v.if_addr;
    n_dm_rd = v.dm_rd; n_dm_wr = v.dm_wr; n_dm_addr = v.dm_addr; n_dm_wdata = v.dm_wdata;
    for (int t = 0; t < 40; t++) begin
      tick();
      n_en += int'(o_mem_en);
      if (o_if_done && got_if < 0) begin got_if = cyc - start; r_if = o_if_r; n_if_req = 0; end
      if (o_dm_done && got_dm < 0) begin got_dm = cyc - start; r_dm = o_dm_r; n_dm_rd = 0; n_dm_wr = 0; end
      if ((!v.if_req || got_if >= 0) && (!(v.dm_rd | v.dm_wr) || got_dm >= 0)) break;
    end
    chk($sformatf("v%0d_if_done_at", idx), got_if, v.e_if);
    chk($sformatf("v%0d_dm_done_at", idx), got_dm, v.e_dm);
    chk($sformatf("v%0d_mem_en_count", idx), n_en, int'(v.if_req) + int'(v.dm_rd | v.dm_wr));
    if (v.if_req) chk($sformatf("v%0d_if_rdata", idx), r_if, v.e_if_r);
    if (v.dm_rd | v.dm_wr) chk($sformatf("v%0d_dm_rdata", idx), r_dm, v.e_dm_r);
    n_if_req = 0; n_dm_rd = 0; n_dm_wr = 0;
    tick(); tick();
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] order[5], exp_order[5];
    int n;

    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = 16'hC000 | 16'(i);
      ref_mem[i] = env_mem[i];
    end
    env_mem[16'h010] = 16'hA5A5; ref_mem[16'h010] = 16'hA5A5;
    env_mem[16'h200] = 16'h1234; ref_mem[16'h200] = 16'h1234;
    for (int i = 0; i < 32; i++) env_v[i] = 0;
    model_reset();

    vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000,  6, -1, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000, 13,  6, 16'hA5A5, 16'h1234};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0300, 16'hBEEF, -1,  6, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0300, 16'h0000, -1,  6, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b1, 16'h0020, 1'b1, 1'b1, 16'h0040, 16'h7777, 13,  6, 16'hC020, 16'hBEEF};
    vecs[5] = '{1'b1, 16'h0300, 1'b1, 1'b0, 16'h0040, 16'h0000, 13,  6, 16'hBEEF, 16'h7777};

    bus.if_req = 0; bus.if_addr = 0; bus.dm_rd = 0; bus.dm_wr = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0;
    #1 rst_n = 1'b0;
    #1 check_zero("por");
    tick(); tick();
    n_rst = 1'b1;
    tick(); tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // data held continuously against a pending fetch
    exp_order = '{16'h0100, 16'h0100, 16'h0100, 16'h0010, 16'h0100};
    n = 0;
    n_if_req = 1; n_if_addr = 16'h0010; n_dm_rd = 1; n_dm_addr = 16'h0100;
    for (int t = 0; t < 80 && n < 5; t++) begin
      tick();
      if (o_mem_en) begin order[n] = o_mem_addr; n++; end
      if (o_if_done) n_if_req = 0;
    end
    chk("streak_grant_count", n, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("streak_grant%0d_addr", i), order[i], exp_order[i]);
    for (int t = 0; t < 20; t++) begin tick(); if (o_dm_done) break; end
    n_dm_rd = 0;
    tick(); tick();

    // asynchronous reset while an access is waiting on memory
    n_if_req = 1; n_if_addr = 16'h0200;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0; bus.if_req = 0; n_if_req = 0; n_rst = 0;
    #1 check_zero("async_rst");
    tick();
    n_rst = 1'b1;
    run_vec(vecs[0], 10);

`ifdef MEM_ARB_PERF_EN
    perf_clr = 1; tick(); perf_clr = 0;
    chk("perf_if_after_clr", perf_if_wait, 0);
    run_vec(vecs[1], 20);
    // run_vec idles two cycles after the last done; counts stay put
    chk("perf_if_wait", perf_if_wait, 13);
    chk("perf_dm_wait", perf_dm_wait, 6);
    n_if_req = 1; n_if_addr = 16'h0010;
    tick();
    perf_clr = 1; tick(); perf_clr = 0;
    chk("perf_clr_if", perf_if_wait, 0);
    chk("perf_clr_dm", perf_dm_wait, 0);
    for (int t = 0; t < 20; t++) begin tick(); if (o_if_done) break; end
    n_if_req = 0; tick(); tick();
`endif

    // random traffic, attributes wander every cycle, occasional fetch flush
    for (int t = 0; t < 3000; t++) begin
      if (m_if_done) n_if_req = ($urandom % 4 == 0);
      else if (n_if_req) begin if ($urandom % 50 == 0) n_if_req = 0; end
      else n_if_req = ($urandom % 3 == 0);
      if ($urandom % 3 == 0) n_if_addr = 16'($urandom_range(0, 31));
      if (m_dm_done || !(n_dm_rd | n_dm_wr)) begin
        if ($urandom % 3 == 0) begin
          n = int'($urandom % 3);
          n_dm_rd = (n != 1); n_dm_wr = (n != 0);
        end else begin
          n_dm_rd = 0; n_dm_wr = 0;
        end
      end
      if ($urandom % 3 == 0) n_dm_addr = 16'($urandom_range(0, 31));
      if ($urandom % 3 == 0) n_dm_wdata = 16'($urandom);
      tick();
    end
    n_if_req = 0; n_dm_rd = 0; n_dm_wr = 0;
    for (int t = 0; t < 12; t++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported, fixed-latency memory between the instruction-fetch requester and the data-memory requester of the 5-stage pipeline. It sequences each access through a small FSM. It returns read data and a one-cycle done pulse per access, and generates the instrMem_stall / dataMem_stall levels consumed by fetch, decode and hazard logic. Data accesses have priority, with a bounded-streak guarantee for fetch.

Parameters:
MEM_LAT, 4, cycles from mem_en assertion to valid mem_rdata (>=1)
MAX_DM_STREAK, 3, consecutive data grants allowed while if_req is pending before fetch is forced a grant (>=1)
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; level, held until if_done
if_addr  in  16  fetch address
if_rdata  out  16  fetch read data, valid while if_done=1
if_done  out  1  one-cycle completion pulse for fetch
instrMem_stall  out  1  if_req & ~if_done
dm_rd  in  1  data read request; level, held until dm_done
dm_wr  in  1  data write request; level, held until dm_done
dm_addr  in  16  data address
dm_wdata  in  16  write data
dm_rdata  out  16  data read data, valid while dm_done=1
dm_done  out  1  one-cycle completion pulse for data
dataMem_stall  out  1  (dm_rd|dm_wr) & ~dm_done
mem_en  out  1  memory access strobe, exactly one cycle per access
mem_wr  out  1  write qualifier for mem_en
mem_addr  out  16  registered address
mem_wdata  out  16  registered write data
mem_rdata  in  16  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, rst_n=0): state=IDLE; streak=0; all outputs 0, including mem_* and *_rdata. Any in-flight access is abandoned; the memory result is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, grant decision in the same cycle:
  - Data wins if (dm_rd|dm_wr) and not (if_req & streak==MAX_DM_STREAK).
  - Otherwise fetch wins if if_req.
  - With no request, stay IDLE.
  - On grant: latch owner, addr, wdata and wr into registers; go to ISSUE.
- Streak update on grant:
  - Data grant while if_req=1: streak+1, saturating.
  - Any fetch grant, or a data grant with if_req=0: streak cleared to 0.
- ISSUE (1 cycle): mem_en=1, mem_wr/mem_addr/mem_wdata from the latched values. Load latency counter with MEM_LAT; go to WAIT.
- WAIT: counter decrements each cycle. In the cycle mem_rdata is valid (MEM_LAT cycles after ISSUE), capture mem_rdata into the owner's rdata register (reads only) and go to DONE.
- DONE (1 cycle): owner's done=1 and rdata valid; the other requester's done=0. Next state is IDLE.
  - The requester must drop or change its request before the next IDLE cycle sees it.
  - A request still asserted in IDLE is a new access.
- Latency, request to done: MEM_LAT+2 cycles (request seen in cycle 0; done in cycle MEM_LAT+2). Minimum inter-grant spacing is MEM_LAT+3 cycles.
- Writes follow the same timing. dm_rdata is held at its previous value; done still pulses.
- dm_rd and dm_wr both high: treated as a write.
- Request attributes (address, data, rd/wr) sampled only at grant. Changes while waiting are ignored until the next grant.
- Request deasserted before done (e.g. pipeline flush of fetch): the access still completes. The done pulse is still produced for the latched owner and may be ignored by the requester.
- rdata registers are cleared only by reset and are otherwise updated only on a read capture.
- Stall outputs are purely combinational from request levels and registered done. No combinational path from mem_rdata to any output.

Optional Feature:
Macro MEM_ARB_PERF_EN.
- Defined: adds outputs perf_if_wait [CNT_W-1:0] and perf_dm_wait [CNT_W-1:0].
  - Each counts cycles its stall output is 1.
  - Counters saturate at all-ones and reset to 0 on rst_n.
  - perf_clr (input, 1 bit) synchronously zeroes both counters; clear wins over increment.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE), owner encoding (OWN_IF=0, OWN_DM=1), default parameter constants.
- Sub-module lat_counter:
  - Loadable down-counter with terminal-count output.
  - Width $clog2(MEM_LAT+1); inputs load and value; output tc.
  - Instantiated once by the FSM.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x0010, MEM_LAT=4, mem returns 0xA5A5 → mem_en in cycle 1; if_done=1 with if_rdata=0xA5A5 in cycle 6; instrMem_stall=1 in cycles 0-5, then 0.
- Simultaneous if_req and dm_rd (addr 0x0200, mem 0x1234) in cycle 0 → data granted first; dm_done in cycle 6 with dm_rdata=0x1234; fetch mem_en in cycle 8; if_done in cycle 13.
- Streak limit: dm_rd held continuously with if_req=1, MAX_DM_STREAK=3 → grants in order DM, DM, DM, IF, DM; the 4th mem_en has mem_addr=if_addr.
- Write: dm_wr=1, dm_addr=0x0300, dm_wdata=0xBEEF → one cycle with mem_en=1, mem_wr=1, mem_addr=0x0300, mem_wdata=0xBEEF; dm_done pulses; dm_rdata unchanged.
- Reset mid-access: rst_n=0 during WAIT → all outputs 0 immediately; after release, the next grant starts cleanly at ISSUE and the stale mem_rdata is never captured.
- MEM_ARB_PERF_EN: the fetch-blocked-by-data scenario above → perf_if_wait=13 and perf_dm_wait=6; perf_clr=1 → both counters 0 next cycle.
